// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: states, opcodes,
// ALUOp and mux selects, plus the bundled control word.
package mips_ctrl_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_RTEX   = 4'd6;
    localparam logic [3:0] S_RTWB   = 4'd7;
    localparam logic [3:0] S_BEQEX  = 4'd8;
    localparam logic [3:0] S_JEX    = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
interface mips_ctrl_if;
    logic [5:0] opcode;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );

    modport slave (
        output opcode,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state
    );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Moore output decode: control word as a pure function of the FSM state.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_RTEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RTWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_ALUOUT;
            end
            S_JEX: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// next-state logic and reset gating of the decoded controls.
//
// state      | meaning
// -----------+------------------------------------------------
// FETCH  (0) | read instruction, load IR, PC <= PC + 4
// DECODE (1) | precompute branch target, dispatch on opcode
// MEMADR (2) | effective address / ADDI sum
// MEMRD  (3) | data memory read at ALUOut
// MEMWB  (4) | MDR -> rt
// MEMWR  (5) | data memory write at ALUOut
// RTEX   (6) | R-type ALU operation
// RTWB   (7) | ALUOut -> rd
// BEQEX  (8) | compare, conditional PC load
// JEX    (9) | jump
// ADDIWB (10)| ALUOut -> rt
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mips_ctrl_if.master bus
);
    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] dec_state;
    ctrl_t      dec;
    logic       strobe_en;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW, OP_ADDI: state_d = S_MEMADR;
                    OP_RTYPE:              state_d = S_RTEX;
                    OP_BEQ:                state_d = S_BEQEX;
                    OP_J:                  state_d = S_JEX;
                    default:               state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                case (bus.opcode)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    OP_ADDI: state_d = S_ADDIWB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_RTEX:   state_d = S_RTWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // During reset the mux selects already present the FETCH setup while
    // every strobe is held off, so an interrupted instruction cannot write.
    assign dec_state = reset ? S_FETCH : state_q;
    assign strobe_en = ~reset;

    mips_ctrl_outdec u_outdec (
        .state (dec_state),
        .ctrl  (dec)
    );

    assign bus.pc_write      = dec.pc_write      & strobe_en;
    assign bus.pc_write_cond = dec.pc_write_cond & strobe_en;
    assign bus.mem_read      = dec.mem_read      & strobe_en;
    assign bus.mem_write     = dec.mem_write     & strobe_en;
    assign bus.ir_write      = dec.ir_write      & strobe_en;
    assign bus.reg_write     = dec.reg_write     & strobe_en;
    assign bus.i_or_d        = dec.i_or_d;
    assign bus.mem_to_reg    = dec.mem_to_reg;
    assign bus.reg_dst       = dec.reg_dst;
    assign bus.alu_src_a     = dec.alu_src_a;
    assign bus.alu_src_b     = dec.alu_src_b;
    assign bus.alu_op        = dec.alu_op;
    assign bus.pc_source     = dec.pc_source;
    assign bus.illegal_op    = strobe_en & (state_q == S_DECODE) & ~is_supported(bus.opcode);
    assign bus.state         = state_q;
endmodule
